// File: rtl/bram_bit_player_if.sv
// bram_bit_player_if: host write port, playback control and serial outputs of the pattern player.
interface bram_bit_player_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int DIV_W  = 16
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              start;
   logic              stop;
   logic [ADDR_W-1:0] last_addr;
   logic [DIV_W-1:0]  bit_div;
   logic              loop;
   logic              sel_out;
   logic              busy;
   logic              done;
   modport master (
      output wr_en, wr_addr, wr_data, start, stop, last_addr, bit_div, loop,
      input  sel_out, busy, done
   );
   modport slave (
      input  wr_en, wr_addr, wr_data, start, stop, last_addr, bit_div, loop,
      output sel_out, busy, done
   );
endinterface

// File: rtl/bram_bit_player.sv
// bram_bit_player: plays a block-RAM bit pattern LSB-first onto sel_out at a programmable bit period.
module bram_bit_player #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int DIV_W  = 16
) (
   input logic              clk,
   input logic              rst_n,
   bram_bit_player_if.slave bus
);
   localparam int BW = $clog2(DATA_W);
   typedef enum logic [1:0] {IDLE, FETCH, PRIME, SHIFT} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, last_q, last_d, nxt_addr, rd_addr;
   logic [DIV_W-1:0]  div_q, div_d, lim_q, lim_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d, rd_data_q;
   logic              loop_q, loop_d, done_q, done_d, rd_en, bit_end, word_end;
   logic [DATA_W-1:0] mem [2**ADDR_W];
   // rd_data_q only changes on a read, so it doubles as the prefetch register
   always_ff @(posedge clk) begin
      if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
      if (rd_en) rd_data_q <= mem[rd_addr];
   end
   assign bit_end  = div_q == lim_q;
   assign word_end = bit_end && bit_q == BW'(DATA_W-1);
   assign nxt_addr = addr_q == last_q ? '0 : addr_q + 1'b1;
   // next word is read on the edge that starts bit DATA_W-1, so it is ready even when bit_div=0
   assign rd_en    = state_q == FETCH || (state_q == SHIFT && bit_end && bit_q == BW'(DATA_W-2));
   assign rd_addr  = state_q == FETCH ? '0 : nxt_addr;
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      last_d  = last_q;
      lim_d   = lim_q;
      loop_d  = loop_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (bus.start && !bus.stop) begin
            state_d = FETCH;
            last_d  = bus.last_addr;
            lim_d   = bus.bit_div;
            loop_d  = bus.loop;
            addr_d  = '0;
            div_d   = '0;
            bit_d   = '0;
         end
         FETCH: state_d = PRIME;
         PRIME: begin
            state_d = SHIFT;
            shift_d = rd_data_q;
         end
         SHIFT: begin
            div_d = bit_end ? '0 : div_q + 1'b1;
            if (bit_end) begin
               bit_d   = bit_q + 1'b1;
               shift_d = shift_q >> 1;
            end
            if (word_end) begin
               bit_d   = '0;
               shift_d = rd_data_q;
               addr_d  = nxt_addr;
               if (addr_q == last_q && !loop_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_q != IDLE && bus.stop) begin
         state_d = IDLE;
         done_d  = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         last_q  <= '0;
         lim_q   <= '0;
         loop_q  <= 1'b0;
         div_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         last_q  <= last_d;
         lim_q   <= lim_d;
         loop_q  <= loop_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         done_q  <= done_d;
      end
   end
   assign bus.sel_out = state_q == SHIFT && shift_q[0];
   assign bus.busy    = state_q != IDLE;
   assign bus.done    = done_q;
endmodule

// File: tb/tb_bram_bit_player.sv
// tb_bram_bit_player: scoreboard bench; expected sel_out streams come from a bench-side memory model.
module tb_bram_bit_player;
   localparam int AW = 8;
   localparam int DW = 8;
   localparam int VW = 16;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int pass_cnt = 0;
   int total_cnt = 0;
   logic [DW-1:0] model [2**AW];
   logic exp_q[$];
   bram_bit_player_if #(.ADDR_W(AW), .DATA_W(DW), .DIV_W(VW)) bus();
   bram_bit_player #(.ADDR_W(AW), .DATA_W(DW), .DIV_W(VW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; model[a] = d;
      tick();
      bus.wr_en = 1'b0;
   endtask

   task automatic push_word(input logic [DW-1:0] w, input int div);
      for (int i = 0; i < DW; i++)
         for (int k = 0; k <= div; k++) exp_q.push_back(w[i]);
   endtask

   task automatic go(input logic [AW-1:0] last, input logic [VW-1:0] div, input logic lp);
      bus.last_addr = last; bus.bit_div = div; bus.loop = lp; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      total_cnt++;
      if ({bus.sel_out, bus.busy, bus.done} !== 3'b000)
         $display("FAIL reset_outputs: got %b want 000", {bus.sel_out, bus.busy, bus.done});
      else pass_cnt++;
      rst_n = 1'b1;
      tick();
      total_cnt++;
      if ({bus.sel_out, bus.busy, bus.done} !== 3'b000)
         $display("FAIL reset_release: got %b want 000", {bus.sel_out, bus.busy, bus.done});
      else pass_cnt++;
   endtask

   task automatic test_single();
      logic e;
      int n = 0;
      wr(0, 8'hA5);
      push_word(8'hA5, 0);
      go(0, 0, 0);
      total_cnt++;
      if (bus.busy !== 1'b1) $display("FAIL single_busy_t1: got %b want 1", bus.busy);
      else pass_cnt++;
      tick(); tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (bus.sel_out !== e) $display("FAIL single_sel[%0d]: got %b want %b", n, bus.sel_out, e);
         else pass_cnt++;
         n++;
         tick();
      end
      total_cnt++;
      if ({bus.sel_out, bus.busy, bus.done} !== 3'b001)
         $display("FAIL single_end: got %b want 001", {bus.sel_out, bus.busy, bus.done});
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.done !== 1'b0) $display("FAIL single_done_once: got %b want 0", bus.done);
      else pass_cnt++;
   endtask

   task automatic test_two_words();
      logic e;
      int n = 0;
      wr(0, 8'hFF);
      wr(1, 8'h00);
      push_word(model[0], 2);
      push_word(model[1], 2);
      go(1, 2, 0);
      tick(); tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (bus.sel_out !== e || bus.done !== 1'b0)
            $display("FAIL two_words[%0d]: got sel=%b done=%b want sel=%b done=0", n, bus.sel_out, bus.done, e);
         else pass_cnt++;
         n++;
         tick();
      end
      total_cnt++;
      if ({bus.sel_out, bus.busy, bus.done} !== 3'b001)
         $display("FAIL two_words_end: got %b want 001", {bus.sel_out, bus.busy, bus.done});
      else pass_cnt++;
      tick();
   endtask

   task automatic test_loop();
      logic e;
      int n = 0;
      for (int r = 0; r < 4; r++) begin
         push_word(model[0], 0);
         push_word(model[1], 0);
      end
      for (int i = 0; i < 5; i++) exp_q.push_back(1'b1);
      go(1, 0, 1);
      tick(); tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (bus.sel_out !== e || bus.done !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL loop[%0d]: got sel=%b done=%b busy=%b want sel=%b done=0 busy=1",
                     n, bus.sel_out, bus.done, bus.busy, e);
         else pass_cnt++;
         n++;
         tick();
      end
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      total_cnt++;
      if ({bus.sel_out, bus.busy, bus.done} !== 3'b000)
         $display("FAIL loop_stop: got %b want 000", {bus.sel_out, bus.busy, bus.done});
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({bus.busy, bus.done} !== 2'b00) $display("FAIL loop_stop_nodone: got %b want 00", {bus.busy, bus.done});
      else pass_cnt++;
   endtask

   task automatic test_rewrite();
      logic e;
      wr(0, 8'h0F);
      push_word(8'h0F, 0);
      push_word(8'hF0, 0);
      push_word(8'hF0, 0);
      go(0, 0, 1);
      tick(); tick();
      for (int i = 0; i < 3 * DW; i++) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (bus.sel_out !== e || bus.busy !== 1'b1)
            $display("FAIL rewrite[%0d]: got sel=%b busy=%b want sel=%b busy=1", i, bus.sel_out, bus.busy, e);
         else pass_cnt++;
         bus.wr_en = i == 2;
         bus.wr_addr = '0;
         bus.wr_data = 8'hF0;
         bus.start = i == 4;
         if (i == 4) begin
            bus.last_addr = 8'd5;
            bus.loop = 1'b0;
         end
         tick();
      end
      model[0] = 8'hF0;
      bus.start = 1'b1; bus.stop = 1'b1;
      tick();
      bus.start = 1'b0; bus.stop = 1'b0;
      total_cnt++;
      if ({bus.sel_out, bus.busy, bus.done} !== 3'b000)
         $display("FAIL start_stop_busy: got %b want 000", {bus.sel_out, bus.busy, bus.done});
      else pass_cnt++;
      bus.start = 1'b1; bus.stop = 1'b1;
      tick();
      bus.start = 1'b0; bus.stop = 1'b0;
      total_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL start_stop_idle: got %b want 0", bus.busy);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic e;
      int n = 0;
      wr(0, 8'h97);
      go(0, 5, 0);
      tick(); tick(); tick(); tick();
      total_cnt++;
      if (bus.sel_out !== 1'b1) $display("FAIL pre_reset_sel: got %b want 1", bus.sel_out);
      else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({bus.sel_out, bus.busy, bus.done} !== 3'b000)
         $display("FAIL async_reset: got %b want 000", {bus.sel_out, bus.busy, bus.done});
      else pass_cnt++;
      tick(); tick();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         total_cnt++;
         if ({bus.sel_out, bus.busy, bus.done} !== 3'b000)
            $display("FAIL post_reset_idle[%0d]: got %b want 000", i, {bus.sel_out, bus.busy, bus.done});
         else pass_cnt++;
      end
      push_word(model[0], 0);
      go(0, 0, 0);
      tick(); tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (bus.sel_out !== e) $display("FAIL mem_kept[%0d]: got %b want %b", n, bus.sel_out, e);
         else pass_cnt++;
         n++;
         tick();
      end
      total_cnt++;
      if (bus.done !== 1'b1) $display("FAIL mem_kept_done: got %b want 1", bus.done);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_full();
      logic e;
      int n = 0;
      for (int a = 0; a < 2**AW; a++) wr(AW'(a), DW'(a) ^ 8'h5A);
      for (int a = 0; a < 2**AW; a++) push_word(model[a], 0);
      go(8'hFF, 0, 0);
      tick(); tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (bus.sel_out !== e || bus.done !== 1'b0)
            $display("FAIL full[w%0d b%0d]: got sel=%b done=%b want sel=%b done=0", n / DW, n % DW, bus.sel_out, bus.done, e);
         else pass_cnt++;
         n++;
         tick();
      end
      total_cnt++;
      if ({bus.sel_out, bus.busy, bus.done} !== 3'b001)
         $display("FAIL full_end: got %b want 001", {bus.sel_out, bus.busy, bus.done});
      else pass_cnt++;
      tick();
   endtask

   initial begin
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.start = 1'b0; bus.stop = 1'b0;
      bus.last_addr = '0; bus.bit_div = '0; bus.loop = 1'b0;
      tick(); tick();
      test_reset();
      test_single();
      test_two_words();
      test_loop();
      test_rewrite();
      test_reset_mid();
      test_full();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
